// File: rtl/video_squ_sync_sep.sv
// video_squ_sync_sep: composite-sync separator recovering H/V/frame counters, blanking and lock flags
module video_squ_sync_sep #(
  parameter int C_H_PX_N       = 780,
  parameter int C_V_LINE_N     = 263,
  parameter int C_H_ACT_PX_N   = 640,
  parameter int C_V_ACT_LINE_N = 240,
  parameter int C_H_SYNC_POS   = 659,
  parameter int C_V_LOAD       = 243,
  parameter int C_LONG_TH      = 200,
  parameter int C_LOCK_N       = 4
) (
  input  logic       CK_i,
  input  logic       XRST_i,
  input  logic       CK_EE_i,
  input  logic       XSYNC_i,
  output logic [9:0] HCTRs_o,
  output logic [8:0] VCTRs_o,
  output logic       FCTR_o,
  output logic       XBLK_o,
  output logic       H_LOCK_o,
  output logic       V_LOCK_o
);
  localparam int LW = $clog2(C_LOCK_N + 1);
  localparam logic [9:0] H_LAST = 10'(C_H_PX_N - 1);
  localparam logic [9:0] H_SYNC = 10'(C_H_SYNC_POS);
  localparam logic [9:0] H_PRE  = 10'(C_H_SYNC_POS - 1);
  localparam logic [9:0] H_ACT  = 10'(C_H_ACT_PX_N);
  localparam logic [8:0] V_LAST = 9'(C_V_LINE_N - 1);
  localparam logic [8:0] V_LD   = 9'(C_V_LOAD);
  localparam logic [8:0] V_ACT  = 9'(C_V_ACT_LINE_N);
  localparam logic [8:0] W_TH   = 9'(C_LONG_TH);
  localparam logic [LW-1:0] L_N = LW'(C_LOCK_N);
  logic          s1_q, s2_q;
  logic [8:0]    wid_q, wid_d;
  logic [9:0]    hctr_q, hctr_d;
  logic [8:0]    vctr_q, vctr_d;
  logic [LW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          fctr_q, fctr_d, xblk_q, xblk_d, hlock_q, hlock_d, vlock_q, vlock_d, lp_q, lp_d;
  logic          fall, rise, lng, h_pre, h_wrap, v_load, v_wrap;
  always_comb begin
    fall    = s2_q & ~s1_q;
    rise    = ~s2_q & s1_q;
    lng     = wid_q >= W_TH;
    h_pre   = hctr_q == H_PRE;
    h_wrap  = ~fall & (hctr_q == H_LAST);
    // only the first long pulse of a V interval re-aligns VCTR
    v_load  = rise & lng & ~lp_q;
    v_wrap  = h_wrap & (vctr_q == V_LAST) & ~v_load;
    wid_d   = fall ? '0 : (~s1_q & ~&wid_q) ? wid_q + 9'd1 : wid_q;
    hctr_d  = fall ? H_SYNC : h_wrap ? '0 : hctr_q + 10'd1;
    hcnt_d  = (fall & h_pre) ? ((hcnt_q == L_N) ? hcnt_q : hcnt_q + LW'(1)) : (fall | h_pre) ? '0 : hcnt_q;
    hlock_d = hcnt_d == L_N;
    vctr_d  = v_load ? V_LD : v_wrap ? '0 : h_wrap ? vctr_q + 9'd1 : vctr_q;
    vcnt_d  = v_load ? ((vctr_q == V_LD) ? ((vcnt_q == L_N) ? vcnt_q : vcnt_q + LW'(1)) : '0) : vcnt_q;
    vlock_d = hlock_d & (vcnt_d == L_N);
    fctr_d  = fctr_q ^ v_wrap;
    lp_d    = rise ? lng : lp_q;
    xblk_d  = hlock_q & vlock_q & (hctr_q < H_ACT) & (vctr_q < V_ACT);
  end
  always_ff @(posedge CK_i) begin
    if (!XRST_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      wid_q   <= '0;
      hctr_q  <= '0;
      vctr_q  <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fctr_q  <= 1'b0;
      xblk_q  <= 1'b0;
      hlock_q <= 1'b0;
      vlock_q <= 1'b0;
      lp_q    <= 1'b0;
    end else if (CK_EE_i) begin
      s1_q    <= XSYNC_i;
      s2_q    <= s1_q;
      wid_q   <= wid_d;
      hctr_q  <= hctr_d;
      vctr_q  <= vctr_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      fctr_q  <= fctr_d;
      xblk_q  <= xblk_d;
      hlock_q <= hlock_d;
      vlock_q <= vlock_d;
      lp_q    <= lp_d;
    end
  end
  assign HCTRs_o  = hctr_q;
  assign VCTRs_o  = vctr_q;
  assign FCTR_o   = fctr_q;
  assign XBLK_o   = xblk_q;
  assign H_LOCK_o = hlock_q;
  assign V_LOCK_o = vlock_q;
endmodule

// File: tb/tb_video_squ_sync_sep.sv
// tb_video_squ_sync_sep: scoreboard bench for a scaled-down and a full-size sync separator
module tb_video_squ_sync_sep;
  logic CK_i = 1'b0, XRST_i, CK_EE_i, XSYNC_i;
  logic [9:0] h0, h1;
  logic [8:0] v0, v1;
  logic f0, f1, xb0, xb1, hl0, hl1, vl0, vl1;
  int ntest = 0, nfail = 0;
  bit g_pause = 1'b0;
  logic [45:0] sb[$];
  // instance 0 uses a shrunk raster so several fields fit in the run
  int PH[2]  = '{80, 780};
  int PV[2]  = '{21, 263};
  int PHA[2] = '{64, 640};
  int PVA[2] = '{16, 240};
  int PSY[2] = '{66, 659};
  int PVL[2] = '{18, 243};
  int PLT[2] = '{20, 200};
  int ms1[2], ms2[2], mrun[2], mh[2], mv[2], mf[2], mxb[2], mhs[2], mvs[2], mlp[2];
  always #5 CK_i = ~CK_i;
  video_squ_sync_sep #(
    .C_H_PX_N(80), .C_V_LINE_N(21), .C_H_ACT_PX_N(64), .C_V_ACT_LINE_N(16),
    .C_H_SYNC_POS(66), .C_V_LOAD(18), .C_LONG_TH(20), .C_LOCK_N(4)
  ) dut_s (
    .CK_i(CK_i), .XRST_i(XRST_i), .CK_EE_i(CK_EE_i), .XSYNC_i(XSYNC_i),
    .HCTRs_o(h0), .VCTRs_o(v0), .FCTR_o(f0), .XBLK_o(xb0), .H_LOCK_o(hl0), .V_LOCK_o(vl0)
  );
  video_squ_sync_sep dut_d (
    .CK_i(CK_i), .XRST_i(XRST_i), .CK_EE_i(CK_EE_i), .XSYNC_i(XSYNC_i),
    .HCTRs_o(h1), .VCTRs_o(v1), .FCTR_o(f1), .XBLK_o(xb1), .H_LOCK_o(hl1), .V_LOCK_o(vl1)
  );
  task automatic cmp(string nm, logic [22:0] g, logic [22:0] x);
    ntest++;
    if (g !== x) begin
      nfail++;
      $display("FAIL %s t=%0t got h=%0d v=%0d f=%0d xb=%0d hl=%0d vl=%0d exp h=%0d v=%0d f=%0d xb=%0d hl=%0d vl=%0d",
               nm, $time, g[22:13], g[12:4], g[3], g[2], g[1], g[0], x[22:13], x[12:4], x[3], x[2], x[1], x[0]);
    end
  endtask
  task automatic chk(string nm, int g, int x);
    ntest++;
    if (g != x) begin
      nfail++;
      $display("FAIL %s t=%0t got %0d exp %0d", nm, $time, g, x);
    end
  endtask
  // cycle-level reference: lock is a streak of on-time events, V lock also needs H lock
  task automatic model(bit r, bit e, bit x);
    for (int k = 0; k < 2; k++) begin
      bit fall, rise, lng, hwrap, vload, hl_o, vl_o;
      if (!r) begin
        ms1[k] = 1; ms2[k] = 1; mrun[k] = 0; mh[k] = 0; mv[k] = 0;
        mf[k] = 0; mxb[k] = 0; mhs[k] = 0; mvs[k] = 0; mlp[k] = 0;
      end else if (e) begin
        fall  = ms2[k] == 1 && ms1[k] == 0;
        rise  = ms2[k] == 0 && ms1[k] == 1;
        lng   = mrun[k] >= PLT[k];
        hl_o  = mhs[k] >= 4;
        vl_o  = hl_o && mvs[k] >= 4;
        mxb[k] = int'(hl_o && vl_o && mh[k] < PHA[k] && mv[k] < PVA[k]);
        hwrap = !fall && mh[k] == PH[k] - 1;
        vload = rise && lng && mlp[k] == 0;
        if (fall) mhs[k] = (mh[k] == PSY[k] - 1) ? mhs[k] + 1 : 0;
        else if (mh[k] == PSY[k] - 1) mhs[k] = 0;
        if (vload) begin
          mvs[k] = (mv[k] == PVL[k]) ? mvs[k] + 1 : 0;
          mv[k] = PVL[k];
        end else if (hwrap) begin
          if (mv[k] == PV[k] - 1) mf[k] = 1 - mf[k];
          mv[k] = (mv[k] + 1) % PV[k];
        end
        mh[k] = fall ? PSY[k] : (mh[k] + 1) % PH[k];
        if (rise) mlp[k] = int'(lng);
        mrun[k] = fall ? 0 : (ms1[k] == 0) ? mrun[k] + 1 : mrun[k];
        ms2[k] = ms1[k];
        ms1[k] = int'(x);
      end
    end
  endtask
  function automatic logic [22:0] pk(int k);
    return {10'(mh[k]), 9'(mv[k]), 1'(mf[k]), 1'(mxb[k]), mhs[k] >= 4, mvs[k] >= 4 && mhs[k] >= 4};
  endfunction
  task automatic cyc(bit r, bit e, bit x);
    XRST_i = r;
    CK_EE_i = e;
    XSYNC_i = x;
    @(posedge CK_i);
    model(r, e, x);
    sb.push_back({pk(0), pk(1)});
    #1;
  endtask
  task automatic emit(bit lvl, int n);
    while (n > 0) begin
      bit e;
      e = g_pause ? ($urandom_range(7) != 0) : 1'b1;
      cyc(1'b1, e, e ? lvl : 1'($urandom_range(1)));
      if (e) n--;
    end
  endtask
  task automatic line(int p, int l, int pre, int gap, bit rp);
    emit(1'b1, pre);
    emit(1'b0, l);
    repeat (gap) cyc(1'b1, 1'b0, 1'($urandom_range(1)));
    if (rp) cyc(1'b0, 1'b1, 1'b1);
    emit(1'b1, p - l - pre - int'(rp));
  endtask
  // kinds: 1 late fall, 2 missing pulse, 3 random jitter, 4 enable gap, 5 reset pulse
  task automatic field(int pl, int kind);
    for (int i = 0; i < 21; i++) begin
      int pre, l, gap;
      bit rp;
      pre = 0; l = (i < 3) ? 40 : 6; gap = 0; rp = 1'b0;
      if (i == pl && kind == 1) pre = 3;
      if (i == pl && kind == 2) l = 0;
      if (i == pl && kind == 4) gap = 10;
      if (i == pl && kind == 5) rp = 1'b1;
      if (kind == 3 && $urandom_range(9) == 0) pre = $urandom_range(3);
      line(80, l, pre, gap, rp);
    end
  endtask
  always @(negedge CK_i) begin
    logic [45:0] x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      cmp("dut_s", {h0, v0, f0, xb0, hl0, vl0}, x[45:23]);
      cmp("dut_d", {h1, v1, f1, xb1, hl1, vl1}, x[22:0]);
    end
  end
  initial begin
    XRST_i = 1'b0;
    CK_EE_i = 1'b1;
    XSYNC_i = 1'b1;
    repeat (5) cyc(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    emit(1'b1, 1700);
    repeat (8) line(780, 58, 0, 0, 1'b0);
    chk("d_hlock", int'(hl1), 1);
    repeat (7) field(-1, 0);
    chk("s_hlock_ideal", int'(hl0), 1);
    chk("s_vlock_ideal", int'(vl0), 1);
    field(8, 1);
    repeat (2) field(-1, 0);
    field(9, 2);
    field(-1, 0);
    field(5, 4);
    g_pause = 1'b1;
    repeat (2) field(-1, 0);
    g_pause = 1'b0;
    chk("s_hlock_pause", int'(hl0), 1);
    chk("s_vlock_pause", int'(vl0), 1);
    field(7, 5);
    repeat (6) field(-1, 0);
    chk("s_hlock_relock", int'(hl0), 1);
    chk("s_vlock_relock", int'(vl0), 1);
    g_pause = 1'b1;
    repeat (4) field(-1, 3);
    g_pause = 1'b0;
    @(negedge CK_i);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
